branch_hazard_ctrl: RTL and testbench

Decode-stage hazard and forwarding controller for the branch-compare datapath. It keeps a shadow scoreboard of the EX, MEM and WB pipeline slots and uses it to drive the two branch operand-forward selects. It stalls fetch and decode while a branch operand cannot yet be forwarded, and squashes the wrong-path fetch when a branch resolves taken. It sits between the decode register, the branch comparator and the F/D/E pipeline registers.

---
 rtl/branch_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_branch_hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   Decode-stage hazard and forwarding controller for the branch comparator.
//   A shadow scoreboard tracks the EX, MEM and WB slots. It drives the two
//   branch operand-forward selects, stalls F/D while an operand cannot be
//   forwarded yet, and squashes the wrong-path fetch on a taken branch.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   validD, branchD          decode slot valid / is beq-bne
//   rsD, rtD, dstD           decode source / destination registers
//   reg_writeD, mem_to_regD  decode writes RF / is a load
//   branch_taken             comparator result (ignored while stalling)
//   fw_branch1/2             00 none, 10 MEM (alu_outM), 01 WB (write_resultW)
//   stallF, stallD, flushE   hazard stall (all three are the same signal)
//   flushD                   wrong-path squash, one cycle per taken branch
//   hazard_err               sticky, set when a stall run exceeds MAX_STALL
//   stall_cnt, taken_cnt     saturating statistics counters

// Per-operand hazard/forward lookup against the three scoreboard slots.
// Slot index 0 = EX, 1 = MEM, 2 = WB.
module bhc_fwd_lane #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0]      src,
  input  logic [2:0]             slot_live,  // valid & writes-RF per slot
  input  logic [2:0][REG_AW-1:0] slot_dst,
  input  logic                   mem_load,
  output logic                   hz,
  output logic [1:0]             fw
);
  logic [2:0] hit;

  always_comb begin
    hit = '0;
    for (int s = 0; s < 3; s++)
      hit[s] = slot_live[s] && (slot_dst[s] == src) && (src != '0);
    // EX result not produced yet; a MEM load only has its address in alu_outM.
    hz = hit[0] | (hit[1] & mem_load);
    fw = 2'b00;
    if (hit[1])      fw = 2'b10;   // MEM wins over WB
    else if (hit[2]) fw = 2'b01;
  end
endmodule

module branch_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int MAX_STALL = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] dstD,
  input  logic              reg_writeD,
  input  logic              mem_to_regD,
  input  logic              branch_taken,
  output logic [1:0]        fw_branch1,
  output logic [1:0]        fw_branch2,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic              flushD,
  output logic              hazard_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);
  localparam int STAGES  = 2;
  localparam int NUM_OPS = 2;
  // run_len must be able to hold MAX_STALL+1 so the overrun is observable.
  localparam int RL_W    = $clog2(MAX_STALL + 2);
  localparam logic [RL_W-1:0] RL_LIMIT = RL_W'(MAX_STALL);

  typedef enum logic {RUN, WAIT} state_t;

  // Scoreboard as shift registers: [0]=EX, [1]=MEM, [2]=WB.
  logic [STAGES:0]             vld_pipe, wr_pipe, ld_pipe;
  logic [STAGES:0][REG_AW-1:0] dst_pipe;

  logic                          is_br, stall, ex_load, flushD_reg;
  logic [NUM_OPS-1:0][REG_AW-1:0] op_src;
  logic [NUM_OPS-1:0]            op_hz;
  logic [NUM_OPS-1:0][1:0]       op_fw;
  logic [STAGES:0]               slot_live;

  state_t          state, state_nxt;
  logic [RL_W-1:0] run_len, run_len_nxt;
  logic            err_q, err_now;

  assign is_br     = validD & branchD;
  assign op_src    = {rtD, rsD};
  assign slot_live = vld_pipe & wr_pipe;

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      bhc_fwd_lane #(.REG_AW(REG_AW)) u_lane (
        .src       (op_src[g]),
        .slot_live (slot_live),
        .slot_dst  (dst_pipe),
        .mem_load  (ld_pipe[1]),
        .hz        (op_hz[g]),
        .fw        (op_fw[g])
      );
    end
  endgenerate

  // One stall covers both operands; it lasts until neither operand hazards.
  assign stall  = is_br & (|op_hz);
  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = is_br & ~stall & branch_taken;

  assign fw_branch1 = (is_br & ~stall) ? op_fw[0] : 2'b00;
  assign fw_branch2 = (is_br & ~stall) ? op_fw[1] : 2'b00;

  // A stalled decode or a squashed wrong-path instruction becomes a bubble.
  assign ex_load = validD & ~stall & ~flushD_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      wr_pipe    <= '0;
      ld_pipe    <= '0;
      dst_pipe   <= '0;
      flushD_reg <= 1'b0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], ex_load};
      wr_pipe    <= {wr_pipe[STAGES-1:0], reg_writeD};
      ld_pipe    <= {ld_pipe[STAGES-1:0], mem_to_regD};
      dst_pipe[STAGES:1] <= dst_pipe[STAGES-1:0];
      dst_pipe[0]        <= dstD;
      flushD_reg <= flushD;
    end
  end

  // Stall-run tracker. run_len counts stall cycles already completed in the
  // current run, so the overrun is flagged in the cycle that exceeds the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      run_len <= '0;
    end else begin
      state   <= state_nxt;
      run_len <= run_len_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    run_len_nxt = run_len;
    err_now     = stall && (run_len >= RL_LIMIT);
    case (state)
      RUN: begin
        if (stall) begin
          state_nxt   = WAIT;
          run_len_nxt = RL_W'(1);
        end
      end
      WAIT: begin
        if (stall) begin
          if (run_len != '1) run_len_nxt = run_len + RL_W'(1);
        end else begin
          state_nxt   = RUN;
          run_len_nxt = '0;
        end
      end
      default: begin
        state_nxt   = RUN;
        run_len_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_now) err_q <= 1'b1;
  end

  assign hazard_err = err_q | err_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (stall  && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushD && !(&taken_cnt)) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl. Each step drives decode inputs,
// queues the hand-derived expected outputs, and compares them at the falling
// edge. A second instance with MAX_STALL=1 shares the inputs so that the
// hazard_err overrun can be observed alongside the default instance.
module tb_branch_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        validD, branchD, reg_writeD, mem_to_regD, branch_taken;
  logic [4:0]  rsD, rtD, dstD;
  logic [1:0]  fw_branch1, fw_branch2;
  logic        stallF, stallD, flushE, flushD, hazard_err;
  logic [15:0] stall_cnt, taken_cnt;
  logic [1:0]  fw1_b, fw2_b;
  logic        stallF_b, stallD_b, flushE_b, flushD_b, err_b;
  logic [15:0] scnt_b, tcnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [1:0]  f1, f2;
    logic        st, fl, e, e1;
    logic [15:0] sc, tc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .validD(validD), .branchD(branchD),
    .rsD(rsD), .rtD(rtD), .dstD(dstD), .reg_writeD(reg_writeD),
    .mem_to_regD(mem_to_regD), .branch_taken(branch_taken),
    .fw_branch1(fw_branch1), .fw_branch2(fw_branch2),
    .stallF(stallF), .stallD(stallD), .flushE(flushE), .flushD(flushD),
    .hazard_err(hazard_err), .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
  );

  branch_hazard_ctrl #(.MAX_STALL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .validD(validD), .branchD(branchD),
    .rsD(rsD), .rtD(rtD), .dstD(dstD), .reg_writeD(reg_writeD),
    .mem_to_regD(mem_to_regD), .branch_taken(branch_taken),
    .fw_branch1(fw1_b), .fw_branch2(fw2_b),
    .stallF(stallF_b), .stallD(stallD_b), .flushE(flushE_b), .flushD(flushD_b),
    .hazard_err(err_b), .stall_cnt(scnt_b), .taken_cnt(tcnt_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] f1, f2,
                      input logic st, fl, e, e1, input logic [15:0] sc, tc);
    exp_t x;
    x.tag = tag; x.f1 = f1; x.f2 = f2; x.st = st; x.fl = fl;
    x.e = e; x.e1 = e1; x.sc = sc; x.tc = tc;
    q.push_back(x);
  endtask

  task automatic check_pop();
    exp_t x;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL queue_empty observed=0 expected=1");
      return;
    end
    x = q.pop_front();
    chk({x.tag, ".fw1"},    16'(fw_branch1), 16'(x.f1));
    chk({x.tag, ".fw2"},    16'(fw_branch2), 16'(x.f2));
    chk({x.tag, ".stallF"}, 16'(stallF),     16'(x.st));
    chk({x.tag, ".stallD"}, 16'(stallD),     16'(x.st));
    chk({x.tag, ".flushE"}, 16'(flushE),     16'(x.st));
    chk({x.tag, ".flushD"}, 16'(flushD),     16'(x.fl));
    chk({x.tag, ".err"},    16'(hazard_err), 16'(x.e));
    chk({x.tag, ".err1"},   16'(err_b),      16'(x.e1));
    chk({x.tag, ".scnt"},   stall_cnt,       x.sc);
    chk({x.tag, ".tcnt"},   taken_cnt,       x.tc);
  endtask

  task automatic drive(input logic v, br, input logic [4:0] rs, rt, dst,
                       input logic wr, ld, tk);
    validD = v; branchD = br; rsD = rs; rtD = rt; dstD = dst;
    reg_writeD = wr; mem_to_regD = ld; branch_taken = tk;
  endtask

  // One clock step: called at posedge+1, checks at the falling edge.
  task automatic cyc(input string tag, input logic v, br, input logic [4:0] rs, rt, dst,
                     input logic wr, ld, tk, input logic [1:0] f1, f2,
                     input logic st, fl, e, e1, input logic [15:0] sc, tc);
    drive(v, br, rs, rt, dst, wr, ld, tk);
    push(tag, f1, f2, st, fl, e, e1, sc, tc);
    @(negedge clk);
    check_pop();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // reset state
    push("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_pop();
    @(posedge clk); #1; rst_n = 1'b1;

    //      tag        v br rs rt dst wr ld tk  f1     f2     st fl e e1 scnt tcnt
    // 1: ALU producer in EX -> one stall, then MEM forward; taken ignored while stalled
    cyc("t1_add",     1, 0, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc("t1_stall",   1, 1, 3, 4, 0, 0, 0, 1, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    cyc("t1_fwd",     1, 1, 3, 4, 0, 0, 0, 1, 2'b10, 2'b00, 0, 1, 0, 0, 1, 0);
    // 4: wrong-path add $7 is squashed; the next branch on $7 sees no producer
    cyc("t4_squash",  1, 0, 1, 2, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
    cyc("t4_bubble",  1, 1, 7, 3, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
    // 2: load producer -> two stalls, then WB forward; $0 never matches
    cyc("t2_lw",      1, 0, 1, 2, 5, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
    cyc("t2_stall1",  1, 1, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 1);
    cyc("t2_stall2",  1, 1, 5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 2, 1);
    cyc("t2_wbfwd",   1, 1, 5, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 1, 3, 1);
    // 3: $6 in MEM and WB, beq $6,$6 -> MEM priority on both operands
    cyc("t3_add_a",   1, 0, 1, 2, 6, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 3, 1);
    cyc("t3_add_b",   1, 0, 1, 2, 6, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 3, 1);
    cyc("t3_idle",    0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 3, 1);
    cyc("t3_beq",     1, 1, 6, 6, 0, 0, 0, 1, 2'b10, 2'b10, 0, 1, 0, 1, 3, 1);
    cyc("t3_after",   0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 3, 2);
    // 6: reset pulled low in the middle of a load stall
    cyc("t6_lw",      1, 0, 1, 2, 9, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 1, 3, 2);
    cyc("t6_stall1",  1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 3, 2);
    drive(1, 1, 9, 1, 0, 0, 0, 0);
    push("t6_stall2", 2'b00, 2'b00, 1, 0, 0, 1, 4, 2);
    @(negedge clk); check_pop();
    #1 rst_n = 1'b0;
    push("t6_async", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    #1 check_pop();
    @(posedge clk); #1; rst_n = 1'b1;
    cyc("t6_empty",   1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    // 5: MAX_STALL=1 instance flags the second stall cycle, and it sticks
    cyc("t5_lw",      1, 0, 1, 2, 10, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc("t5_stall1",  1, 1, 10, 10, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    cyc("t5_stall2",  1, 1, 10, 10, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 1, 1, 0);
    cyc("t5_wb",      1, 1, 10, 10, 0, 0, 0, 1, 2'b01, 2'b01, 0, 1, 0, 1, 2, 0);
    cyc("t5_after",   0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2, 1);
    // validD=0 with a would-be hazard: no stall, no squash
    cyc("nv_lw",      1, 0, 1, 2, 11, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 2, 1);
    cyc("nv_branch",  0, 1, 11, 11, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 1, 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
